// File: rtl/calc1_req_collector.sv
// calc1_req_collector
// Per-port request front end for the calc1 design. It captures the two-cycle
// request protocol (command + operand1, then operand2), rejects unknown
// commands, and queues complete requests in a small FIFO. The FIFO head is
// offered to the shared ALU arbiter through a valid/ready handshake.
module calc1_req_collector #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 8
) (
    input  logic              c_clk,
    input  logic              reset_n,
    input  logic [0:3]        req_cmd_in,
    input  logic [0:DATA_W-1] req_data_in,
    input  logic              alu_ready,
    output logic              alu_valid,
    output logic [0:3]        alu_cmd,
    output logic [0:DATA_W-1] alu_op1,
    output logic [0:DATA_W-1] alu_op2,
    output logic              inv_cmd,
    output logic              ovf_drop,
    output logic [0:CNT_W-1]  drop_cnt,
    output logic              busy
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic {
        IDLE,
        OP2
    } state_t;

    state_t state;
    state_t next_state;

    logic [3:0]        cmd_q;
    logic [DATA_W-1:0] op1_q;

    logic [3:0]        mem_cmd [DEPTH];
    logic [DATA_W-1:0] mem_op1 [DEPTH];
    logic [DATA_W-1:0] mem_op2 [DEPTH];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    logic cmd_ok;
    logic do_pop;
    logic has_space;
    logic do_push;
    logic do_drop;
    logic do_inv;

    logic             inv_q;
    logic             ovf_q;
    logic [CNT_W-1:0] drop_q;

    // State register for the request-capture FSM
    always_ff @(posedge c_clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state: a non-NOP command starts a request, operand2 always follows
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (req_cmd_in != 4'd0) next_state = OP2;
            OP2:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Decode what happens when a request completes in the operand2 cycle
    always_comb begin
        busy   = (state == OP2);
        cmd_ok = 1'b0;
        case (cmd_q)
            4'd1, 4'd2, 4'd5, 4'd6: cmd_ok = 1'b1;
            default:                cmd_ok = 1'b0;
        endcase
        do_pop    = (count != '0) && alu_ready;
        // a full FIFO still has room when its head leaves on the same edge
        has_space = (count < (AW+1)'(DEPTH)) || do_pop;
        do_push   = busy && cmd_ok && has_space;
        do_drop   = busy && cmd_ok && !has_space;
        do_inv    = busy && !cmd_ok;
    end

    // Hold command and operand1 while waiting for operand2
    always_ff @(posedge c_clk or negedge reset_n) begin
        if (!reset_n) begin
            cmd_q <= '0;
            op1_q <= '0;
        end else if (state == IDLE && req_cmd_in != 4'd0) begin
            cmd_q <= req_cmd_in;
            op1_q <= req_data_in;
        end
    end

    // FIFO storage; operand2 is written straight from the input bus
    always_ff @(posedge c_clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_cmd[i] <= '0;
                mem_op1[i] <= '0;
                mem_op2[i] <= '0;
            end
        end else if (do_push) begin
            mem_cmd[wr_ptr] <= cmd_q;
            mem_op1[wr_ptr] <= op1_q;
            mem_op2[wr_ptr] <= req_data_in;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH
    always_ff @(posedge c_clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Error pulses and the saturating drop counter
    always_ff @(posedge c_clk or negedge reset_n) begin
        if (!reset_n) begin
            inv_q  <= 1'b0;
            ovf_q  <= 1'b0;
            drop_q <= '0;
        end else begin
            inv_q <= do_inv;
            ovf_q <= do_drop;
            if (do_drop && drop_q != '1) drop_q <= drop_q + 1'b1;
        end
    end

    assign alu_valid = (count != '0);
    assign alu_cmd   = mem_cmd[rd_ptr];
    assign alu_op1   = mem_op1[rd_ptr];
    assign alu_op2   = mem_op2[rd_ptr];
    assign inv_cmd   = inv_q;
    assign ovf_drop  = ovf_q;
    assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_calc1_req_collector.sv
// tb_calc1_req_collector
// Self-checking bench: expected requests go into a scoreboard queue when
// driven and are compared whenever the DUT hands its head to the arbiter.
module tb_calc1_req_collector;

    localparam int DEPTH  = 4;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 8;

    logic              c_clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [0:3]        req_cmd_in = '0;
    logic [0:DATA_W-1] req_data_in = '0;
    logic              alu_ready = 1'b0;
    logic              alu_valid;
    logic [0:3]        alu_cmd;
    logic [0:DATA_W-1] alu_op1;
    logic [0:DATA_W-1] alu_op2;
    logic              inv_cmd;
    logic              ovf_drop;
    logic [0:CNT_W-1]  drop_cnt;
    logic              busy;

    typedef struct packed {
        logic [3:0]  cmd;
        logic [31:0] op1;
        logic [31:0] op2;
    } req_t;

    req_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   exp_drops = 0;

    calc1_req_collector #(.DEPTH(DEPTH), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .c_clk(c_clk),
        .reset_n(reset_n),
        .req_cmd_in(req_cmd_in),
        .req_data_in(req_data_in),
        .alu_ready(alu_ready),
        .alu_valid(alu_valid),
        .alu_cmd(alu_cmd),
        .alu_op1(alu_op1),
        .alu_op2(alu_op2),
        .inv_cmd(inv_cmd),
        .ovf_drop(ovf_drop),
        .drop_cnt(drop_cnt),
        .busy(busy)
    );

    // Free-running clock
    always #5 c_clk = ~c_clk;

    // Scoreboard: every handshake must deliver the oldest expected request
    always @(negedge c_clk) begin
        req_t e;
        if (reset_n === 1'b1 && alu_valid === 1'b1 && alu_ready === 1'b1) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("[TB] FAIL pop_unexpected: got cmd=%h op1=%h op2=%h, want no entry", alu_cmd, alu_op1, alu_op2);
            end else begin
                e = sb.pop_front();
                if (alu_cmd !== e.cmd || alu_op1 !== e.op1 || alu_op2 !== e.op2) begin
                    bad++;
                    $display("[TB] FAIL pop_data: got %h/%h/%h want %h/%h/%h", alu_cmd, alu_op1, alu_op2, e.cmd, e.op1, e.op2);
                end
            end
        end
    end

    task automatic tick();
        @(posedge c_clk);
        #1;
    endtask

    task automatic send_req(input logic [3:0] cmd, input logic [31:0] d1, input logic [31:0] d2, input logic [3:0] op2_cmd);
        req_cmd_in  = cmd;
        req_data_in = d1;
        tick();
        req_cmd_in  = op2_cmd;
        req_data_in = d2;
        tick();
        req_cmd_in  = 4'd0;
        req_data_in = '0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #12;
        total++;
        if (alu_valid !== 1'b0 || busy !== 1'b0 || inv_cmd !== 1'b0 || ovf_drop !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_flags: got v=%b b=%b i=%b o=%b want 0000", alu_valid, busy, inv_cmd, ovf_drop);
        end
        total++;
        if (drop_cnt !== 8'h00 || alu_cmd !== 4'h0 || alu_op1 !== 32'h0 || alu_op2 !== 32'h0) begin
            bad++;
            $display("[TB] FAIL reset_data: got cnt=%h cmd=%h op1=%h op2=%h want all 0", drop_cnt, alu_cmd, alu_op1, alu_op2);
        end
        @(negedge c_clk);
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_single_add();
        alu_ready = 1'b1;
        sb.push_back({4'd1, 32'hFFFF0000, 32'h0000FFFF});
        req_cmd_in  = 4'd1;
        req_data_in = 32'hFFFF0000;
        tick();
        total++;
        if (busy !== 1'b1 || alu_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL add_cmd_cycle: got busy=%b valid=%b want 1 0", busy, alu_valid);
        end
        req_cmd_in  = 4'd0;
        req_data_in = 32'h0000FFFF;
        tick();
        total++;
        if (alu_valid !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL add_valid: got valid=%b busy=%b want 1 0", alu_valid, busy);
        end
        total++;
        if (alu_cmd !== 4'd1 || alu_op1 !== 32'hFFFF0000 || alu_op2 !== 32'h0000FFFF) begin
            bad++;
            $display("[TB] FAIL add_head: got %h/%h/%h want 1/ffff0000/0000ffff", alu_cmd, alu_op1, alu_op2);
        end
        req_data_in = '0;
        tick();
        total++;
        if (alu_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL add_popped: got valid=%b want 0", alu_valid);
        end
        alu_ready = 1'b0;
    endtask

    task automatic test_overflow();
        alu_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) sb.push_back({4'd5, 32'h0F0F0F0F, 32'h4});
            send_req(4'd5, 32'h0F0F0F0F, 32'h4, 4'd0);
            if (i < 4) begin
                total++;
                if (ovf_drop !== 1'b0 || alu_valid !== 1'b1) begin
                    bad++;
                    $display("[TB] FAIL ovf_fill%0d: got drop=%b valid=%b want 0 1", i, ovf_drop, alu_valid);
                end
            end else begin
                exp_drops++;
                total++;
                if (ovf_drop !== 1'b1 || drop_cnt !== 8'(exp_drops)) begin
                    bad++;
                    $display("[TB] FAIL ovf_fifth: got drop=%b cnt=%0d want 1 %0d", ovf_drop, drop_cnt, exp_drops);
                end
            end
        end
        tick();
        total++;
        if (ovf_drop !== 1'b0) begin
            bad++;
            $display("[TB] FAIL ovf_pulse_len: got %b want 0", ovf_drop);
        end
        alu_ready = 1'b1;
        repeat (4) tick();
        alu_ready = 1'b0;
        total++;
        if (alu_valid !== 1'b0 || sb.size() != 0) begin
            bad++;
            $display("[TB] FAIL ovf_drain: got valid=%b left=%0d want 0 0", alu_valid, sb.size());
        end
    endtask

    task automatic test_invalid();
        logic [3:0] bad_cmds [3];
        bad_cmds[0] = 4'd3;
        bad_cmds[1] = 4'd9;
        bad_cmds[2] = 4'd15;
        alu_ready = 1'b1;
        req_cmd_in  = 4'd0;
        req_data_in = 32'hCAFEF00D;
        tick();
        total++;
        if (busy !== 1'b0 || alu_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL nop_idle: got busy=%b valid=%b want 0 0", busy, alu_valid);
        end
        for (int i = 0; i < 3; i++) begin
            send_req(bad_cmds[i], 32'h12345678, 32'h1, 4'd0);
            total++;
            if (inv_cmd !== 1'b1 || alu_valid !== 1'b0 || ovf_drop !== 1'b0) begin
                bad++;
                $display("[TB] FAIL inv_pulse cmd=%0d: got inv=%b valid=%b drop=%b want 1 0 0", bad_cmds[i], inv_cmd, alu_valid, ovf_drop);
            end
            tick();
            total++;
            if (inv_cmd !== 1'b0 || alu_valid !== 1'b0) begin
                bad++;
                $display("[TB] FAIL inv_after cmd=%0d: got inv=%b valid=%b want 0 0", bad_cmds[i], inv_cmd, alu_valid);
            end
        end
        alu_ready = 1'b0;
    endtask

    task automatic test_full_push_pop();
        req_t r;
        req_t e5;
        alu_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            r = {(i % 2 == 0) ? 4'd1 : 4'd2, 32'hA000_0000 + 32'(i), 32'hB000_0000 + 32'(i)};
            sb.push_back(r);
            send_req(r.cmd, r.op1, r.op2, 4'd0);
        end
        e5 = {4'd6, 32'h5555_AAAA, 32'h0000_0003};
        sb.push_back(e5);
        req_cmd_in  = e5.cmd;
        req_data_in = e5.op1;
        tick();
        alu_ready   = 1'b1;
        req_cmd_in  = 4'd0;
        req_data_in = e5.op2;
        tick();
        alu_ready   = 1'b0;
        req_data_in = '0;
        total++;
        if (ovf_drop !== 1'b0 || alu_valid !== 1'b1) begin
            bad++;
            $display("[TB] FAIL full_pushpop: got drop=%b valid=%b want 0 1", ovf_drop, alu_valid);
        end
        total++;
        if (alu_cmd !== 4'd2 || alu_op1 !== 32'hA000_0001 || alu_op2 !== 32'hB000_0001) begin
            bad++;
            $display("[TB] FAIL full_head: got %h/%h/%h want 2/a0000001/b0000001", alu_cmd, alu_op1, alu_op2);
        end
        send_req(4'd1, 32'hDEAD, 32'hBEEF, 4'd0);
        exp_drops++;
        total++;
        if (ovf_drop !== 1'b1 || drop_cnt !== 8'(exp_drops)) begin
            bad++;
            $display("[TB] FAIL full_still_full: got drop=%b cnt=%0d want 1 %0d", ovf_drop, drop_cnt, exp_drops);
        end
        alu_ready = 1'b1;
        repeat (4) tick();
        alu_ready = 1'b0;
        total++;
        if (alu_valid !== 1'b0 || sb.size() != 0) begin
            bad++;
            $display("[TB] FAIL full_drain: got valid=%b left=%0d want 0 0", alu_valid, sb.size());
        end
    endtask

    task automatic test_back_to_back();
        req_t r;
        logic [3:0] cmds [6];
        cmds[0] = 4'd1; cmds[1] = 4'd2; cmds[2] = 4'd5;
        cmds[3] = 4'd6; cmds[4] = 4'd2; cmds[5] = 4'd1;
        alu_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            r = {cmds[i], $urandom(), $urandom()};
            sb.push_back(r);
            send_req(r.cmd, r.op1, r.op2, (i % 2 == 1) ? 4'd2 : 4'd0);
        end
        tick();
        alu_ready = 1'b0;
        total++;
        if (alu_valid !== 1'b0 || sb.size() != 0 || busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL b2b_end: got valid=%b left=%0d busy=%b want 0 0 0", alu_valid, sb.size(), busy);
        end
    endtask

    task automatic test_reset_mid();
        alu_ready = 1'b0;
        sb.push_back({4'd1, 32'h11, 32'h22});
        send_req(4'd1, 32'h11, 32'h22, 4'd0);
        sb.push_back({4'd2, 32'h33, 32'h44});
        send_req(4'd2, 32'h33, 32'h44, 4'd0);
        req_cmd_in  = 4'd1;
        req_data_in = 32'hAAAA;
        tick();
        total++;
        if (busy !== 1'b1 || alu_valid !== 1'b1) begin
            bad++;
            $display("[TB] FAIL mid_pre: got busy=%b valid=%b want 1 1", busy, alu_valid);
        end
        reset_n     = 1'b0;
        req_cmd_in  = 4'd0;
        req_data_in = 32'h5555;
        sb.delete();
        exp_drops = 0;
        #1;
        total++;
        if (alu_valid !== 1'b0 || busy !== 1'b0 || drop_cnt !== 8'h00) begin
            bad++;
            $display("[TB] FAIL mid_reset: got valid=%b busy=%b cnt=%0d want 0 0 0", alu_valid, busy, drop_cnt);
        end
        #2;
        reset_n = 1'b1;
        tick();
        total++;
        if (alu_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL mid_no_push: got valid=%b busy=%b want 0 0", alu_valid, busy);
        end
        req_data_in = '0;
        tick();
        total++;
        if (alu_valid !== 1'b0 || ovf_drop !== 1'b0 || inv_cmd !== 1'b0) begin
            bad++;
            $display("[TB] FAIL mid_after: got valid=%b drop=%b inv=%b want 0 0 0", alu_valid, ovf_drop, inv_cmd);
        end
    endtask

    task automatic test_saturation();
        alu_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sb.push_back({4'd5, 32'(i), 32'(i + 100)});
            send_req(4'd5, 32'(i), 32'(i + 100), 4'd0);
        end
        for (int i = 0; i < 258; i++) begin
            send_req(4'd2, 32'(i), ~32'(i), 4'd0);
            exp_drops = (exp_drops < 255) ? exp_drops + 1 : 255;
            total++;
            if (ovf_drop !== 1'b1 || drop_cnt !== 8'(exp_drops)) begin
                bad++;
                $display("[TB] FAIL sat_drop%0d: got drop=%b cnt=%0d want 1 %0d", i, ovf_drop, drop_cnt, exp_drops);
            end
        end
        total++;
        if (drop_cnt !== 8'hFF) begin
            bad++;
            $display("[TB] FAIL sat_final: got %h want ff", drop_cnt);
        end
        alu_ready = 1'b1;
        repeat (4) tick();
        alu_ready = 1'b0;
        total++;
        if (alu_valid !== 1'b0 || sb.size() != 0) begin
            bad++;
            $display("[TB] FAIL sat_drain: got valid=%b left=%0d want 0 0", alu_valid, sb.size());
        end
    endtask

    // Run every scenario in order, then report
    initial begin
        test_reset();
        test_single_add();
        test_overflow();
        test_invalid();
        test_full_push_pop();
        test_back_to_back();
        test_reset_mid();
        test_saturation();
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/calc1_req_collector.md
Name: calc1_req_collector

Overview:
- Per-port request front end of the calc1 design; one instance per port, four in total.
- Sits directly downstream of the port stimulus: captures the two-cycle request protocol (cmd + operand1 in cycle 1, operand2 in cycle 2) and validates the command.
- Queues complete requests in a small FIFO and presents them to the shared ALU arbiter over a valid/ready handshake.
- Invalid commands and overflowed requests are reported on error outputs and never reach the ALU.

Parameters:
DEPTH, 4, FIFO entries (power of two, >=2)
DATA_W, 32, operand width
CNT_W, 8, width of saturating drop counter

Ports:
c_clk  input  1  clock, all state updates on rising edge
reset_n  input  1  asynchronous active-low reset
req_cmd_in  input  [0:3]  request command (0 NOP, 1 ADD, 2 SUB, 5 LSH, 6 RSH)
req_data_in  input  [0:DATA_W-1]  operand1 in cmd cycle, operand2 in following cycle
alu_ready  input  1  arbiter accepts head entry this cycle
alu_valid  output  1  FIFO non-empty
alu_cmd  output  [0:3]  head entry command
alu_op1  output  [0:DATA_W-1]  head entry operand1
alu_op2  output  [0:DATA_W-1]  head entry operand2
inv_cmd  output  1  one-cycle pulse: invalid command completed
ovf_drop  output  1  one-cycle pulse: valid request dropped, FIFO full
drop_cnt  output  [0:CNT_W-1]  saturating count of ovf_drop pulses
busy  output  1  high while in OP2 state

Behaviour:
- Reset (async assert, sync-safe release): state IDLE; FIFO empty, pointers/count 0; drop_cnt 0. All outputs 0, including alu_cmd/op1/op2. Any half-captured request is discarded.
- FSM states: IDLE, OP2.
- IDLE, req_cmd_in==0: stay IDLE.
- IDLE, req_cmd_in!=0: latch cmd and op1 = req_data_in; go to OP2; busy=1 next cycle.
- OP2: latch op2 = req_data_in and ignore req_cmd_in (a non-NOP here is not a new request). Go to IDLE. Back-to-back requests therefore need at least one cycle between command cycles.
- At the OP2 edge, command in {1,2,5,6}: push {cmd, op1, op2} to FIFO if there is space, else drop.
- At the OP2 edge, any other command: no push; inv_cmd pulses for the following cycle.
- Drop: ovf_drop pulses for one cycle; drop_cnt increments, saturating at all-ones.
- Space rule: count<DEPTH, or count==DEPTH with a pop in the same cycle (simultaneous push+pop when full is accepted, count unchanged).
- Pop: alu_valid && alu_ready at a rising edge removes the head. alu_ready while empty has no effect.
- Head outputs are registered FIFO storage, stable while alu_valid=1 and alu_ready=0. When empty they hold the last popped values and must not be relied on.
- Latency: cmd sampled at edge N, op2 at edge N+1; alu_valid=1 after edge N+1 if the FIFO was empty.
- Push and pop same cycle when non-empty: count unchanged; order preserved (strict FIFO).
- Pointers wrap modulo DEPTH; count width is log2(DEPTH)+1.
- Arithmetic: no operand modification; the block only stores data.

Test Plan:
- Reset then ADD 0xFFFF0000 / 0x0000FFFF, alu_ready=1 -> alu_valid high exactly one cycle after op2 edge with cmd=1, op1=0xFFFF0000, op2=0x0000FFFF; popped next edge; alu_valid low after.
- alu_ready=0, five valid requests (LSH 0x0F0F0F0F/4 repeated) -> first 4 queued, fifth gives one ovf_drop pulse, drop_cnt=1; then alu_ready=1 drains 4 entries in order.
- Command 3 with 0x12345678 / 0x1 -> inv_cmd one pulse after op2 edge, no push, alu_valid stays 0.
- FIFO full, alu_ready=1, new request completes on the same edge as a pop -> push accepted, no ovf_drop, count stays DEPTH.
- reset_n asserted low mid-request (in OP2) with 2 entries queued -> immediately alu_valid=0, busy=0, drop_cnt=0; following op2 cycle produces no push.
- 256 dropped requests with CNT_W=8 -> drop_cnt saturates at 0xFF, ovf_drop still pulses.
